// File: rtl/param_shift_register_pkg.sv
// ============================================================================
// Module : param_shift_register_pkg
// Brief  : Op and state encodings shared by the universal shift register.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package param_shift_register_pkg;

    typedef enum logic [2:0] {
        OP_HOLD = 3'b000,
        OP_LOAD = 3'b001,
        OP_CLR  = 3'b010,
        OP_SHL1 = 3'b011,
        OP_SHR1 = 3'b100,
        OP_ASR1 = 3'b101,
        OP_ROL1 = 3'b110,
        OP_ROR1 = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_e;

    // Only shift/rotate ops may be repeated by the run sequencer.
    function automatic logic is_shift(input op_e o);
        return o inside {OP_SHL1, OP_SHR1, OP_ASR1, OP_ROL1, OP_ROR1};
    endfunction

endpackage

`default_nettype wire

// File: rtl/param_shift_register_step_unit.sv
// ============================================================================
// Module : shift_step_unit
// Brief  : One combinational step of clear/shift/rotate on a WIDTH-bit word.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module shift_step_unit
    import param_shift_register_pkg::*;
#(
    parameter int WIDTH = 10
) (
    input  logic [WIDTH-1:0] d,
    input  op_e              op,
    input  logic             ser_in,
    output logic [WIDTH-1:0] next_d,
    output logic             next_ser
);

    // HOLD/LOAD outputs are don't-care here; the top handles those ops.
    always_comb begin
        next_d   = d;
        next_ser = 1'b0;
        case (op)
            OP_CLR: begin
                next_d   = '0;
                next_ser = 1'b0;
            end
            OP_SHL1: begin
                next_d   = {d[WIDTH-2:0], ser_in};
                next_ser = d[WIDTH-1];
            end
            OP_SHR1: begin
                next_d   = {ser_in, d[WIDTH-1:1]};
                next_ser = d[0];
            end
            OP_ASR1: begin
                next_d   = {d[WIDTH-1], d[WIDTH-1:1]};
                next_ser = d[0];
            end
            OP_ROL1: begin
                next_d   = {d[WIDTH-2:0], d[WIDTH-1]};
                next_ser = d[WIDTH-1];
            end
            OP_ROR1: begin
                next_d   = {d[0], d[WIDTH-1:1]};
                next_ser = d[0];
            end
            default: begin
                next_d   = d;
                next_ser = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/param_shift_register.sv
// ============================================================================
// Module : param_shift_register
// Brief  : WIDTH-bit universal register with a multi-cycle shift-by-N run.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module param_shift_register
    import param_shift_register_pkg::*;
#(
    parameter int WIDTH   = 10,
    parameter int SHAMT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         op,
    input  logic               start,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   data_in,
    input  logic               ser_in,
    output logic [WIDTH-1:0]   data_out,
    output logic               ser_out,
    output logic               busy,
    output logic               done
);

    state_e             r_state;
    op_e                r_op;
    logic [SHAMT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_data;
    logic               r_ser;
    logic               r_busy;
    logic               r_done;

    op_e                w_op_in;
    op_e                w_step_op;
    logic [WIDTH-1:0]   w_next_d;
    logic               w_next_ser;

    assign w_op_in   = op_e'(op);
    assign w_step_op = (r_state == RUN) ? r_op : w_op_in;

    shift_step_unit #(
        .WIDTH (WIDTH)
    ) u_step (
        .d        (r_data),
        .op       (w_step_op),
        .ser_in   (ser_in),
        .next_d   (w_next_d),
        .next_ser (w_next_ser)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_op    <= OP_HOLD;
            r_cnt   <= '0;
            r_data  <= '0;
            r_ser   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (r_state == RUN) begin
            r_data <= w_next_d;
            r_ser  <= w_next_ser;
            r_cnt  <= r_cnt - SHAMT_W'(1);
            if (r_cnt == SHAMT_W'(1)) begin
                r_state <= FIN;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
            end
        end else begin
            // IDLE and FIN accept new work identically.
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            if (start && is_shift(w_op_in)) begin
                r_op <= w_op_in;
                if (shamt == '0) begin
                    r_state <= FIN;
                    r_done  <= 1'b1;
                end else begin
                    r_data <= w_next_d;
                    r_ser  <= w_next_ser;
                    r_cnt  <= shamt - SHAMT_W'(1);
                    if (shamt == SHAMT_W'(1)) begin
                        r_state <= FIN;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                    end
                end
            end else begin
                case (w_op_in)
                    OP_HOLD: ;
                    OP_LOAD: r_data <= data_in;
                    default: begin
                        r_data <= w_next_d;
                        r_ser  <= w_next_ser;
                    end
                endcase
            end
        end
    end

    assign data_out = r_data;
    assign ser_out  = r_ser;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

`default_nettype wire

// File: tb/tb_param_shift_register.sv
// Bench for param_shift_register: directed vector table, a rotate-by-WIDTH
// sequence, and randomized traffic against an arithmetic reference model.
`default_nettype none

module tb_param_shift_register;

    localparam int W  = 10;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    op;
    logic          start;
    logic [SW-1:0] shamt;
    logic [W-1:0]  data_in;
    logic          ser_in;
    logic [W-1:0]  data_out;
    logic          ser_out;
    logic          busy;
    logic          done;

    int n_total = 0;
    int n_pass  = 0;

    param_shift_register #(.WIDTH(W), .SHAMT_W(SW)) dut (
        .clk      (clk),
        .rst      (rst),
        .op       (op),
        .start    (start),
        .shamt    (shamt),
        .data_in  (data_in),
        .ser_in   (ser_in),
        .data_out (data_out),
        .ser_out  (ser_out),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic [2:0]    op;
        logic          start;
        logic [SW-1:0] shamt;
        logic [W-1:0]  din;
        logic          sin;
        logic [W-1:0]  ed;
        logic          es;
        logic          eb;
        logic          edn;
        string         name;
    } vec_t;

    vec_t vecs[25];

    task automatic drive(input logic r, input logic [2:0] o, input logic s,
                         input logic [SW-1:0] sh, input logic [W-1:0] di, input logic si);
        rst = r; op = o; start = s; shamt = sh; data_in = di; ser_in = si;
    endtask

    task automatic check(input string name, input logic [W-1:0] ed, input logic es,
                         input logic eb, input logic edn);
        n_total++;
        if (data_out === ed && ser_out === es && busy === eb && done === edn) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got data_out=%h ser_out=%b busy=%b done=%b, expected %h %b %b %b",
                     name, data_out, ser_out, busy, done, ed, es, eb, edn);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int step_model(input int o, input int d, input int sin, inout int s);
        int m = 1 << W;
        int top = d / (m / 2);
        int bot = d % 2;
        case (o)
            2: begin s = 0; return 0; end
            3: begin s = top; return (d * 2) % m + sin; end
            4: begin s = bot; return sin * (m / 2) + d / 2; end
            5: begin s = bot; return top * (m / 2) + d / 2; end
            6: begin s = top; return (d * 2) % m + top; end
            7: begin s = bot; return bot * (m / 2) + d / 2; end
            default: return d;
        endcase
    endfunction

    initial begin
        int m_d, m_s, m_rem, m_op, m_busy, m_done;
        drive(1, 0, 0, 0, 0, 0);

        vecs[0]  = '{1, 3'd0, 0, 4'd0, 10'h000, 0, 10'h000, 0, 0, 0, "reset"};
        vecs[1]  = '{0, 3'd1, 0, 4'd0, 10'h2B5, 0, 10'h2B5, 0, 0, 0, "load"};
        vecs[2]  = '{0, 3'd4, 0, 4'd0, 10'h000, 1, 10'h35A, 1, 0, 0, "shr1"};
        vecs[3]  = '{0, 3'd1, 0, 4'd0, 10'h2B5, 0, 10'h2B5, 1, 0, 0, "load_keeps_ser"};
        vecs[4]  = '{0, 3'd6, 1, 4'd3, 10'h000, 0, 10'h16B, 1, 1, 0, "rol3_s1"};
        vecs[5]  = '{0, 3'd2, 0, 4'd0, 10'h000, 0, 10'h2D6, 0, 1, 0, "rol3_s2_op_ignored"};
        vecs[6]  = '{0, 3'd2, 1, 4'd7, 10'h3FF, 0, 10'h1AD, 1, 0, 1, "rol3_done"};
        vecs[7]  = '{0, 3'd0, 0, 4'd0, 10'h000, 0, 10'h1AD, 1, 0, 0, "hold"};
        vecs[8]  = '{0, 3'd1, 0, 4'd0, 10'h200, 0, 10'h200, 1, 0, 0, "load200"};
        vecs[9]  = '{0, 3'd5, 1, 4'd4, 10'h000, 1, 10'h300, 0, 1, 0, "asr4_s1"};
        vecs[10] = '{0, 3'd0, 0, 4'd0, 10'h000, 1, 10'h380, 0, 1, 0, "asr4_s2"};
        vecs[11] = '{0, 3'd0, 0, 4'd0, 10'h000, 1, 10'h3C0, 0, 1, 0, "asr4_s3"};
        vecs[12] = '{0, 3'd0, 0, 4'd0, 10'h000, 1, 10'h3E0, 0, 0, 1, "asr4_done"};
        vecs[13] = '{0, 3'd1, 0, 4'd0, 10'h155, 0, 10'h155, 0, 0, 0, "load155"};
        vecs[14] = '{0, 3'd3, 1, 4'd0, 10'h000, 1, 10'h155, 0, 0, 1, "shamt0_done"};
        vecs[15] = '{0, 3'd0, 0, 4'd0, 10'h000, 0, 10'h155, 0, 0, 0, "shamt0_after"};
        vecs[16] = '{0, 3'd1, 0, 4'd0, 10'h3FF, 0, 10'h3FF, 0, 0, 0, "load3ff"};
        vecs[17] = '{0, 3'd3, 1, 4'd9, 10'h000, 0, 10'h3FE, 1, 1, 0, "shl9_s1"};
        vecs[18] = '{0, 3'd0, 0, 4'd0, 10'h000, 0, 10'h3FC, 1, 1, 0, "shl9_s2"};
        vecs[19] = '{0, 3'd0, 0, 4'd0, 10'h000, 0, 10'h3F8, 1, 1, 0, "shl9_s3"};
        vecs[20] = '{1, 3'd1, 1, 4'd5, 10'h111, 0, 10'h000, 0, 0, 0, "rst_mid_run"};
        vecs[21] = '{0, 3'd1, 0, 4'd0, 10'h0AB, 0, 10'h0AB, 0, 0, 0, "load_after_rst"};
        vecs[22] = '{0, 3'd0, 0, 4'd0, 10'h000, 0, 10'h0AB, 0, 0, 0, "no_done_after_rst"};
        vecs[23] = '{0, 3'd2, 1, 4'd3, 10'h000, 0, 10'h000, 0, 0, 0, "clr_start_is_single"};
        vecs[24] = '{0, 3'd1, 0, 4'd0, 10'h0AB, 0, 10'h0AB, 0, 0, 0, "reload"};

        for (int i = 0; i < 25; i++) begin
            drive(vecs[i].rst, vecs[i].op, vecs[i].start, vecs[i].shamt, vecs[i].din, vecs[i].sin);
            tick();
            check(vecs[i].name, vecs[i].ed, vecs[i].es, vecs[i].eb, vecs[i].edn);
        end

        // Back-to-back runs: ROR by 1 then, accepted in FIN, ROR by WIDTH.
        drive(0, 3'd7, 1, 4'd1, 10'h000, 0);
        tick();
        check("ror1_done", 10'h255, 1, 0, 1);
        drive(0, 3'd7, 1, 4'd10, 10'h000, 0);
        tick();
        check("rorW_from_fin", 10'h32A, 1, 1, 0);
        drive(0, 3'd1, 1, 4'd2, 10'h3FF, 0);
        for (int i = 0; i < 8; i++) tick();
        check("rorW_last_busy", 10'h0AB, 0, 1, 0);
        tick();
        check("rorW_restores", 10'h255, 1, 0, 1);

        // Randomized traffic against the arithmetic model.
        drive(1, 0, 0, 0, 0, 0);
        tick();
        m_d = 0; m_s = 0; m_rem = 0; m_op = 0; m_busy = 0; m_done = 0;
        for (int c = 0; c < 3000; c++) begin
            logic          r_rst   = ($urandom_range(0, 99) == 0);
            logic [2:0]    r_op    = 3'($urandom_range(0, 7));
            logic          r_start = ($urandom_range(0, 3) == 0);
            logic [SW-1:0] r_sh    = SW'($urandom_range(0, 15));
            logic [W-1:0]  r_din   = W'($urandom);
            logic          r_sin   = 1'($urandom);
            drive(r_rst, r_op, r_start, r_sh, r_din, r_sin);
            if (r_rst) begin
                m_d = 0; m_s = 0; m_rem = 0; m_busy = 0; m_done = 0;
            end else if (m_rem > 0) begin
                m_d = step_model(m_op, m_d, int'(r_sin), m_s);
                m_rem--;
                m_busy = (m_rem > 0);
                m_done = (m_rem == 0);
            end else if (r_start && r_op >= 3) begin
                m_op = r_op;
                if (r_sh == 0) begin
                    m_busy = 0; m_done = 1;
                end else begin
                    m_d = step_model(m_op, m_d, int'(r_sin), m_s);
                    m_rem = int'(r_sh) - 1;
                    m_busy = (m_rem > 0);
                    m_done = (m_rem == 0);
                end
            end else begin
                m_busy = 0; m_done = 0;
                if (r_op == 1) m_d = int'(r_din);
                else if (r_op != 0) m_d = step_model(int'(r_op), m_d, int'(r_sin), m_s);
            end
            tick();
            check("random", W'(m_d), 1'(m_s), 1'(m_busy), 1'(m_done));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
